uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver: next generation of the fixed 8N1 receive path in UART_Main.
//  Adds configurable data width, bit period, parity mode and stop-bit count.
//  Adds start-glitch rejection, parity/framing error flags, and a valid/ready output
//  handshake with overrun detection.
//  Sits between the board serial pin and the packet/LED logic. One byte-wide word per frame.
// PARAMETERS
//  CLKS_PER_BIT  8   clk cycles per serial bit; >=4, even
//  DATA_BITS     8   data bits per frame, 5..9, LSB first
//  PARITY        0   0 = none, 1 = even, 2 = odd
//  STOP_BITS     1   1 or 2
// PORTS
//  clk         in   1          system clock; single clock domain
//  clr         in   1          reset; synchronous, active-high
//  TxD         in   1          serial line from host transmitter, idle high; asynchronous
//  rx_data     out  DATA_BITS  received word; stable while rx_valid=1
//  rx_valid    out  1          word available in holding register
//  rx_ready    in   1          consumer accepts the word on clk when rx_valid & rx_ready
//  parity_err  out  1          parity status of the word in rx_data; qualified by rx_valid
//  frame_err   out  1          a stop bit sampled low; qualified by rx_valid
//  overrun     out  1          1-cycle pulse: completed frame dropped, holding register full
//  busy        out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset (clr=1 at a clk edge): all outputs return to 0; FSM to IDLE; counters to 0.
//   The sync flops reset to 1. Abandon any frame in progress; the holding register is cleared.
//  Input sync: 2-flop synchronizer on TxD gives rx_s. This adds 2 clk of latency.
//   All decisions use rx_s. The previous value, rx_q, is kept for edge detection.
//  Start condition: a falling edge, rx_q=1 and rx_s=0, is detected in IDLE.
//   A line stuck low never re-triggers.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: on start condition, clear bit counter, load half-bit count, go to START.
//   START: sample at CLKS_PER_BIT/2 clk after the edge (mid-bit). If rx_s=1, the start
//    was a glitch: return to IDLE with no output. Otherwise go to DATA.
//   DATA: sample every CLKS_PER_BIT clk; shift in LSB-first. After DATA_BITS samples,
//    go to PARITY if PARITY!=0, otherwise to STOP.
//   PARITY: one sample. Error if (XOR of data ^ sample) != (PARITY==2).
//   STOP: STOP_BITS samples, each CLKS_PER_BIT apart. Any low sample sets a local
//    frame error. After the last stop sample, do the commit and go straight to IDLE.
//    Do not wait for the end of the bit, so back-to-back frames are received.
//  Bit timer: the counter reloads to CLKS_PER_BIT-1 on each sample. The tick comes at 0.
//  Commit (the cycle of the last stop sample):
//   Holding register empty, or drained this cycle (rx_valid & rx_ready): load rx_data,
//    parity_err, frame_err. rx_valid=1 on the next clk.
//   Holding register full and not drained: drop the frame, keep the old contents,
//    overrun=1 for one clk.
//  Handshake: rx_valid is cleared on the clk after rx_valid & rx_ready, unless a commit
//   happens in the same cycle, in which case rx_valid stays 1 with new data.
//   rx_data/flags do not change while rx_valid=1 && !rx_ready.
//  Latency: rx_valid rises 1 clk after the final stop-bit mid-sample.
//   From TxD that is 2 clk of sync plus the sampling point.
//  DATA_BITS=9 with PARITY!=0 is legal. Frame length = 1+DATA_BITS+(PARITY!=0)+STOP_BITS.
//  A frame error on a 0x00 word is reported only as frame_err; there is no separate
//   break flag.
// STRUCTURE
//  uart_pkg: localparams for PARITY_NONE/EVEN/ODD, FSM state encodings (3-bit), and a
//   clog2-based width function for the counters.
//  Sub-module uart_bit_timer: down-counter with load_half/load_full/tick. Reused later by
//   the parametrised TX.
//  Top-level: synchronizer, FSM, shift register, parity accumulator, holding register.
// TESTING  (clk period 20 ns; CLKS_PER_BIT=8 -> 160 ns/bit unless noted)
//  1 8N1: send 0xDB (start,1,1,0,1,1,0,1,1,stop), rx_ready=1
//    -> rx_data=0xDB, rx_valid pulses 1 clk, both error flags 0.
//  2 Glitch: TxD low for 60 ns in idle -> no rx_valid, busy returns 0 within 5 clk.
//    Then a real 0x55 frame is received correctly.
//  3 PARITY=1: send 0xA5 with parity bit 0 -> parity_err=0.
//    Same frame with parity 1 -> parity_err=1, rx_data=0xA5.
//  4 Framing and stuck line: stop bit held low -> frame_err=1.
//    TxD stuck low for 40 bit times afterwards -> no further rx_valid.
//  5 Back-to-back with rx_ready=0: send 0x11 then 0x22
//    -> rx_data stays 0x11, overrun pulses once at the 0x22 commit.
//    Then rx_ready=1 drains 0x11 and rx_valid drops.
//  6 Reset mid-frame: clr=1 for 1 clk during bit 3 -> all outputs 0 next clk.
//    Remainder of the frame ignored; next frame 0x3C received intact.
//    Also repeat test 1 with DATA_BITS=7, STOP_BITS=2 -> rx_data=7'h5B.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and helpers for the parametrised UART
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Bits needed for a counter that must hold values 0..max_value.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period down-counter with half/full reload and zero tick
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic clr,
    input  logic load_half,
    input  logic load_full,
    output logic tick
);

    localparam int TW = cnt_width(CLKS_PER_BIT - 1);
    // Loading N makes the tick arrive N clocks later, so a half load lands on mid-bit
    // and each full reload keeps samples exactly one bit period apart.
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt;

    // Reload on request, otherwise count down and rest at zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (load_half) begin
            cnt <= HALF;
        end else if (load_full) begin
            cnt <= FULL;
        end else if (cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with parity/framing flags and valid/ready output
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 TxD,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BW = cnt_width(((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS) - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD_SENSE = 1'(PARITY == PARITY_ODD);
    localparam logic          HAS_PAR   = 1'(PARITY != PARITY_NONE);

    logic                 rx_meta, rx_s, rx_q;
    logic [2:0]           state;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_acc, par_bad, ferr_loc;
    logic                 tick, load_half, load_full;
    logic                 start_cond, commit;

    // Two-flop synchronizer plus one history flop; idle-high so reset creates no edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= TxD;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    // Only a genuine high-to-low transition starts a frame, so a stuck-low line stays quiet.
    assign start_cond = (state == ST_IDLE) && rx_q && !rx_s;
    assign load_half  = start_cond;
    assign load_full  = tick && (state != ST_IDLE);
    assign commit     = (state == ST_STOP) && tick && (bit_cnt == LAST_STOP);
    assign busy       = (state != ST_IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .clr      (clr),
        .load_half(load_half),
        .load_full(load_full),
        .tick     (tick)
    );

    // Frame FSM: sample on each timer tick, shift data LSB first, accumulate parity and stop status.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_acc   <= 1'b0;
            par_bad   <= 1'b0;
            ferr_loc  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_cond) begin
                        state    <= ST_START;
                        bit_cnt  <= '0;
                        par_acc  <= 1'b0;
                        par_bad  <= 1'b0;
                        ferr_loc <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        par_acc   <= par_acc ^ rx_s;
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= HAS_PAR ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        par_bad <= ((par_acc ^ rx_s) != ODD_SENSE);
                        bit_cnt <= '0;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (!rx_s) begin
                            ferr_loc <= 1'b1;
                        end
                        if (bit_cnt == LAST_STOP) begin
                            state <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Holding register: accept a finished frame if empty or draining now, else flag overrun.
    always_ff @(posedge clk) begin
        if (clr) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid   <= 1'b1;
                    rx_data    <= shift_reg;
                    parity_err <= HAS_PAR & par_bad;
                    frame_err  <= ferr_loc | ~rx_s;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param (8N1, 8E1, 7N2 instances)
module tb_uart_rx_param;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [2:0] txd = 3'b111;
    logic [2:0] rdy = 3'b111;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [2:0] v, pe, fe, ov, bz;

    exp_t q0[$], q1[$], q2[$];
    int   errors = 0;
    int   checks = 0;
    int   ovr_seen [3];
    int   ovr_exp  [3];

    always #10 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .clr(clr), .TxD(txd[0]), .rx_data(d0), .rx_valid(v[0]), .rx_ready(rdy[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .busy(bz[0]));

    uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .clr(clr), .TxD(txd[1]), .rx_data(d1), .rx_valid(v[1]), .rx_ready(rdy[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .busy(bz[1]));

    uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .clr(clr), .TxD(txd[2]), .rx_data(d2), .rx_valid(v[2]), .rx_ready(rdy[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .busy(bz[2]));

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor side: compare each accepted word against the oldest expectation.
    task automatic mon(input int i, input int data, input logic p, input logic f);
        exp_t e;
        int   n;
        n = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL u%0d_unexpected_word: got %0h expected none", i, data);
        end else begin
            case (i)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("u%0d_data", i), data, int'(e.data));
            chk($sformatf("u%0d_parity_err", i), int'(p), int'(e.perr));
            chk($sformatf("u%0d_frame_err", i), int'(f), int'(e.ferr));
        end
    endtask

    always @(negedge clk) begin
        if (!clr) begin
            if (v[0] && rdy[0]) mon(0, int'(d0), pe[0], fe[0]);
            if (v[1] && rdy[1]) mon(1, int'(d1), pe[1], fe[1]);
            if (v[2] && rdy[2]) mon(2, int'(d2), pe[2], fe[2]);
            for (int i = 0; i < 3; i++) begin
                if (ov[i]) ovr_seen[i]++;
            end
        end
    end

    // Reference model: build the serial frame from the format rules and predict the result.
    task automatic send_frame(input int i, input logic [8:0] data_in, input logic bad_par,
                              input logic [1:0] stop_lo, input int gap, input int rst_at,
                              input bit want);
        int       db, par, sb;
        logic     bits[$];
        logic [8:0] data;
        logic     pb;
        exp_t     e;
        db   = (i == 2) ? 7 : 8;
        par  = (i == 1) ? 1 : 0;
        sb   = (i == 2) ? 2 : 1;
        data = data_in & ((9'd1 << db) - 9'd1);
        bits.push_back(1'b0);
        for (int k = 0; k < db; k++) bits.push_back(data[k]);
        if (par != 0) begin
            pb = ^data;
            if (par == 2) pb = ~pb;
            bits.push_back(pb ^ bad_par);
        end
        for (int s = 0; s < sb; s++) bits.push_back(~stop_lo[s]);
        e.data = data;
        e.perr = (par != 0) && bad_par;
        e.ferr = (sb == 2) ? |stop_lo : stop_lo[0];
        if (want) begin
            case (i)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        for (int k = 0; k < bits.size(); k++) begin
            txd[i] = bits[k];
            if (k == rst_at) begin
                tick(3);
                clr = 1'b1;
                tick(1);
                clr = 1'b0;
                chk("rst_mid_valid", int'(v[0]), 0);
                chk("rst_mid_data", int'(d0), 0);
                chk("rst_mid_busy", int'(bz[0]), 0);
                chk("rst_mid_flags", int'({pe[0], fe[0], ov[0]}), 0);
                tick(4);
            end else begin
                tick(8);
            end
        end
        txd[i] = 1'b1;
        tick(gap * 8);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          gap;
        logic [1:0]  slo;
        logic        bad;
        for (int i = 0; i < 3; i++) begin
            ovr_seen[i] = 0;
            ovr_exp[i]  = 0;
        end
        tick(3);
        clr = 1'b0;
        chk("reset_valid", int'(v), 0);
        chk("reset_busy", int'(bz), 0);
        chk("reset_data0", int'(d0), 0);
        chk("reset_flags", int'({pe, fe, ov}), 0);

        // 8N1 and 7N2 basic frames
        send_frame(0, 9'h0DB, 1'b0, 2'b00, 2, -1, 1'b1);
        send_frame(2, 9'h0DB, 1'b0, 2'b00, 2, -1, 1'b1);

        // Start glitch of 3 clocks, then a real frame
        txd[0] = 1'b0;
        tick(3);
        txd[0] = 1'b1;
        tick(5);
        chk("glitch_busy", int'(bz[0]), 0);
        tick(8);
        send_frame(0, 9'h055, 1'b0, 2'b00, 1, -1, 1'b1);

        // Even parity: correct then wrong parity bit
        send_frame(1, 9'h0A5, 1'b0, 2'b00, 1, -1, 1'b1);
        send_frame(1, 9'h0A5, 1'b1, 2'b00, 1, -1, 1'b1);

        // Stop bit low, then line stuck low for 40 bit times
        send_frame(0, 9'h03A, 1'b0, 2'b01, 0, -1, 1'b1);
        txd[0] = 1'b0;
        tick(40 * 8);
        txd[0] = 1'b1;
        tick(16);
        chk("stuck_busy", int'(bz[0]), 0);

        // Back-to-back into a full holding register
        rdy[0] = 1'b0;
        send_frame(0, 9'h011, 1'b0, 2'b00, 0, -1, 1'b1);
        send_frame(0, 9'h022, 1'b0, 2'b00, 1, -1, 1'b0);
        ovr_exp[0]++;
        chk("ovr_hold_valid", int'(v[0]), 1);
        chk("ovr_hold_data", int'(d0), 'h11);
        chk("ovr_count", ovr_seen[0], ovr_exp[0]);
        rdy[0] = 1'b1;
        tick(1);
        chk("drain_valid", int'(v[0]), 0);

        // Reset during bit 3 while a word is held, then a clean frame
        rdy[0] = 1'b0;
        send_frame(0, 9'h077, 1'b0, 2'b00, 1, -1, 1'b1);
        send_frame(0, 9'h0F8, 1'b0, 2'b00, 1, 4, 1'b0);
        q0.delete();
        rdy[0] = 1'b1;
        tick(8);
        chk("post_rst_valid", int'(v[0]), 0);
        send_frame(0, 9'h03C, 1'b0, 2'b00, 1, -1, 1'b1);

        // Randomised frames on every format
        for (int n = 0; n < 24; n++) begin
            int i;
            i   = n % 3;
            bad = (i == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            slo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            gap = $urandom_range(0, 2);
            if (slo != 2'b00 && gap == 0) gap = 1;
            send_frame(i, 9'($urandom), bad, slo, gap, -1, 1'b1);
        end

        tick(20);
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_overruns", i), ovr_seen[i], ovr_exp[i]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
